// File: rtl/rp_disk_addr_ctr.sv
// rp_disk_addr_ctr: RPxx sector/track/cylinder address registers with carry increment, eop/iae flags and shift-add LBA conversion
module rp_disk_addr_ctr #(
   parameter int DATA_W = 36,
   parameter int SA_W   = 6,
   parameter int TA_W   = 6,
   parameter int TA_OFS = 8,
   parameter int CA_W   = 10,
   parameter int LBA_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              da_write,
   input  logic              dc_write,
   input  logic [SA_W-1:0]   last_sector,
   input  logic [TA_W-1:0]   last_track,
   input  logic [CA_W-1:0]   last_cyl,
   input  logic              inc_sector,
   input  logic              lba_start,
   output logic [15:0]       da,
   output logic [15:0]       dc,
   output logic              iae,
   output logic              eop,
   output logic              lba_busy,
   output logic              lba_done,
   output logic [LBA_W-1:0]  lba
);
   localparam int MW = TA_W > SA_W ? TA_W : SA_W;
   localparam int CW = MW > 1 ? $clog2(MW) : 1;
   typedef enum logic [1:0] {IDLE, MUL_T, MUL_S, DONE} lbaStateT;
   lbaStateT state, stateNext;
   logic [SA_W-1:0] sector, secSnap, spSh;
   logic [TA_W-1:0] track, trkSnap, tpSh;
   logic [CA_W-1:0] cyl;
   logic [TA_W:0] tp1;
   logic [SA_W:0] sp1;
   logic [LBA_W-1:0] acc, mcand, accNext, sumT, sumS;
   logic [CW-1:0] cnt;
   logic spTop, lastCnt, mulBit, secWrap, trkWrap, cylWrap;
   // address views, geometry compare and the shift-add step
   always_comb begin
      da = '0;
      da[SA_W-1:0] = sector;
      da[TA_OFS +: TA_W] = track;
      dc = '0;
      dc[CA_W-1:0] = cyl;
      iae = (sector > last_sector) || (track > last_track) || (cyl > last_cyl);
      secWrap = sector == last_sector;
      trkWrap = track == last_track;
      cylWrap = cyl == last_cyl;
      tp1 = {1'b0, last_track} + (TA_W+1)'(1);
      sp1 = {1'b0, last_sector} + (SA_W+1)'(1);
      lastCnt = cnt == '0;
      mulBit = state == MUL_T ? tpSh[TA_W-1] : spSh[SA_W-1];
      accNext = (acc << 1) + (mulBit ? mcand : '0);
      sumT = accNext + LBA_W'(trkSnap);
      sumS = accNext + LBA_W'(secSnap);
   end
   // address registers: clear, field loads, then the sector->track->cylinder carry chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sector <= '0;
         track <= '0;
         cyl <= '0;
         eop <= 1'b0;
      end else if (clr) begin
         sector <= '0;
         track <= '0;
         cyl <= '0;
         eop <= 1'b0;
      end else if (da_write || dc_write) begin
         if (da_write) begin
            sector <= data_in[SA_W-1:0];
            track <= data_in[TA_OFS +: TA_W];
         end
         if (dc_write) begin
            cyl <= data_in[CA_W-1:0];
            eop <= 1'b0;
         end
      end else if (inc_sector && !iae) begin
         sector <= secWrap ? '0 : sector + SA_W'(1);
         if (secWrap) track <= trkWrap ? '0 : track + TA_W'(1);
         if (secWrap && trkWrap) cyl <= cylWrap ? '0 : cyl + CA_W'(1);
         if (secWrap && trkWrap && cylWrap) eop <= 1'b1;
      end
   end
   // LBA FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= stateNext;
   end
   // LBA FSM next state and status outputs
   always_comb begin
      stateNext = state;
      lba_busy = state == MUL_T || state == MUL_S;
      lba_done = state == DONE;
      if (clr) stateNext = IDLE;
      else if (state == IDLE) stateNext = lba_start ? MUL_T : IDLE;
      else if (state == MUL_T) stateNext = lastCnt ? MUL_S : MUL_T;
      else if (state == MUL_S) stateNext = lastCnt ? DONE : MUL_S;
      else stateNext = IDLE;
   end
   // LBA datapath: snapshot, MSB-first shift-add over (last+1) with its top bit preloaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         mcand <= '0;
         tpSh <= '0;
         spSh <= '0;
         spTop <= 1'b0;
         trkSnap <= '0;
         secSnap <= '0;
         cnt <= '0;
         lba <= '0;
      end else if (!clr) begin
         if (state == IDLE && lba_start) begin
            mcand <= LBA_W'(cyl);
            acc <= tp1[TA_W] ? LBA_W'(cyl) : '0;
            tpSh <= tp1[TA_W-1:0];
            spSh <= sp1[SA_W-1:0];
            spTop <= sp1[SA_W];
            trkSnap <= track;
            secSnap <= sector;
            cnt <= CW'(TA_W - 1);
         end else if (state == MUL_T) begin
            tpSh <= tpSh << 1;
            mcand <= lastCnt ? sumT : mcand;
            acc <= lastCnt ? (spTop ? sumT : '0) : accNext;
            cnt <= lastCnt ? CW'(SA_W - 1) : cnt - CW'(1);
         end else if (state == MUL_S) begin
            spSh <= spSh << 1;
            acc <= accNext;
            cnt <= cnt - CW'(1);
            if (lastCnt) lba <= sumS;
         end
      end
   end
endmodule
